pipelined_addsub: RTL



---
 rtl/pipelined_addsub.sv | 88 ++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add/subtract with the carry chain split into STAGES registered chunks, behind a ready/valid stream.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = WIDTH / STAGES;
    logic adv;
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // RW: operand bits still unconsumed on entry to this stage (this chunk and above)
        localparam int RW = WIDTH - k * CW;
        logic                v_p;
        logic                c_p;
        logic [RW-1:0]       al;
        logic [RW-1:0]       bl;
        logic [CW:0]         r;
        logic [(k+1)*CW-1:0] s_n;
        if (k == 0) begin : g_first
            assign v_p = in_valid;
            assign al  = a;
            assign bl  = sub ? ~b : b;
            assign c_p = sub ? ~cin : cin;
            assign s_n = r[CW-1:0];
        end else begin : g_next
            assign v_p = g_st[k-1].g_mid.v_q;
            assign al  = g_st[k-1].g_mid.a_q;
            assign bl  = g_st[k-1].g_mid.b_q;
            assign c_p = g_st[k-1].g_mid.c_q;
            assign s_n = {r[CW-1:0], g_st[k-1].g_mid.s_q};
        end
        assign r = {1'b0, al[CW-1:0]} + {1'b0, bl[CW-1:0]} + {{CW{1'b0}}, c_p};
        if (k < STAGES - 1) begin : g_mid
            logic                v_q;
            logic                c_q;
            logic [RW-CW-1:0]    a_q;
            logic [RW-CW-1:0]    b_q;
            logic [(k+1)*CW-1:0] s_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= v_p;
                    c_q <= r[CW];
                    a_q <= al[RW-1:CW];
                    b_q <= bl[RW-1:CW];
                    s_q <= s_n;
                end
            end
        end else begin : g_last
            // the top chunk carries the operand sign bits, so overflow is resolved here
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_p;
                    sum       <= s_n;
                    cout      <= r[CW];
                    ovf       <= (al[RW-1] == bl[RW-1]) && (s_n[WIDTH-1] != al[RW-1]);
                    zero      <= s_n == '0;
                end
            end
        end
    end
endmodule
